turn_timer_ctrl: RTL

Sequences a per-turn countdown for the two-player game logic. It owns a one-second prescaler derived from the system clock and tracks whose turn it is. It handles start, pause and stop requests, and reports a turn timeout to the game FSM. It sits between the game controller (move_done, start/stop) and the display and turn logic (player, secs_left, timeout).

---
 rtl/turn_timer_ctrl_if.sv | 26 ++
 rtl/turn_timer_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/turn_timer_ctrl_if.sv
// Control/status bundle between the game controller and the turn timer.
// The master side drives game requests; the slave side reports turn status.
interface turn_timer_ctrl_if #(
  parameter int SEC_W = 4
);
  logic             start_game;
  logic             stop_game;
  logic             pause;
  logic             move_done;
  logic             player;
  logic [SEC_W-1:0] secs_left;
  logic             running;
  logic             paused;
  logic             timeout;
  logic             sec_tick;

  modport master (
    output start_game, stop_game, pause, move_done,
    input  player, secs_left, running, paused, timeout, sec_tick
  );

  modport slave (
    input  start_game, stop_game, pause, move_done,
    output player, secs_left, running, paused, timeout, sec_tick
  );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Two-player turn countdown: one-second prescaler, per-turn seconds counter,
// pause/stop handling and a single-cycle timeout pulse when a turn expires.
// Every output comes straight from a flop; the prescaler only advances in RUN.
module turn_timer_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURN_SECS = 10,
  parameter int SEC_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  turn_timer_ctrl_if.slave   bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] TURN_V     = SEC_W'(TURN_SECS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRE,
    S_SWITCH
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             player_q, player_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;
  logic             timeout_q, timeout_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Seconds counter stops at zero instead of wrapping around.
  function automatic logic [SEC_W-1:0] sat_dec(input logic [SEC_W-1:0] v);
    return (v == '0) ? '0 : v - SEC_W'(1);
  endfunction

  assign wrap = (presc_q == PRESC_LAST);

  // State and registered outputs; async active-low reset returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      player_q  <= 1'b0;
      secs_q    <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      timeout_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      player_q  <= player_d;
      secs_q    <= secs_d;
      running_q <= running_d;
      paused_q  <= paused_d;
      timeout_q <= timeout_d;
      tick_q    <= tick_d;
    end
  end

  // Next-state and next-output decode; stop_game overrides everything.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    player_d  = player_q;
    secs_d    = secs_q;
    timeout_d = 1'b0;
    tick_d    = 1'b0;

    if (bus.stop_game) begin
      state_d = S_IDLE;
      secs_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_game) begin
            state_d  = S_RUN;
            player_d = 1'b0;
            secs_d   = TURN_V;
            presc_d  = '0;
          end
        end
        S_RUN: begin
          // A finished move wins over any tick or expiry in the same cycle.
          if (bus.move_done) begin
            state_d = S_SWITCH;
          end else if (wrap) begin
            // The tick is honoured even when pause arrives with it.
            presc_d = '0;
            tick_d  = 1'b1;
            secs_d  = sat_dec(secs_q);
            if (secs_q == SEC_W'(1)) begin
              state_d = S_EXPIRE;
            end else if (bus.pause) begin
              state_d = S_PAUSED;
            end
          end else if (bus.pause) begin
            state_d = S_PAUSED;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSED: begin
          if (!bus.pause) begin
            state_d = S_RUN;
          end
        end
        S_EXPIRE: begin
          timeout_d = 1'b1;
          state_d   = S_SWITCH;
        end
        S_SWITCH: begin
          player_d = ~player_q;
          secs_d   = TURN_V;
          presc_d  = '0;
          state_d  = bus.pause ? S_PAUSED : S_RUN;
        end
        default: begin
          state_d = S_IDLE;
          secs_d  = '0;
        end
      endcase
    end

    running_d = (state_d == S_RUN);
    paused_d  = (state_d == S_PAUSED);
  end

  assign bus.player    = player_q;
  assign bus.secs_left = secs_q;
  assign bus.running   = running_q;
  assign bus.paused    = paused_q;
  assign bus.timeout   = timeout_q;
  assign bus.sec_tick  = tick_q;

endmodule
